// File: rtl/result_stage_pipe.sv
// Per-pipe result staging s1..s7 with write-back from s8 for the SPU-lite core.
// Define RESULT_PIPE_CHECK_EN to drive the sticky protocol error output `err`.
module result_stage_pipe #(
  parameter int PIPE        = 0,
  parameter int REG_DATA_WD = 128,
  parameter int ADDR_WD     = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   iss_valid,
  input  logic [ADDR_WD-1:0]     iss_rt_addr,
  input  logic [2:0]             iss_idx,
  input  logic                   lat2_valid,
  input  logic [REG_DATA_WD-1:0] lat2_data,
  input  logic                   lat3_valid,
  input  logic [REG_DATA_WD-1:0] lat3_data,
  input  logic                   lat4_valid,
  input  logic [REG_DATA_WD-1:0] lat4_data,
  input  logic                   lat6_valid,
  input  logic [REG_DATA_WD-1:0] lat6_data,
  input  logic                   lat7_valid,
  input  logic [REG_DATA_WD-1:0] lat7_data,
  output logic [ADDR_WD-1:0]     rf_addr_s2,
  output logic [ADDR_WD-1:0]     rf_addr_s3,
  output logic [ADDR_WD-1:0]     rf_addr_s4,
  output logic [ADDR_WD-1:0]     rf_addr_s5,
  output logic [ADDR_WD-1:0]     rf_addr_s6,
  output logic [ADDR_WD-1:0]     rf_addr_s7,
  output logic [REG_DATA_WD-1:0] rf_data_s2,
  output logic [REG_DATA_WD-1:0] rf_data_s3,
  output logic [REG_DATA_WD-1:0] rf_data_s4,
  output logic [REG_DATA_WD-1:0] rf_data_s5,
  output logic [REG_DATA_WD-1:0] rf_data_s6,
  output logic [REG_DATA_WD-1:0] rf_data_s7,
  output logic [2:0]             rf_idx_s2,
  output logic [2:0]             rf_idx_s3,
  output logic [2:0]             rf_idx_s4,
  output logic [2:0]             rf_idx_s5,
  output logic [2:0]             rf_idx_s6,
  output logic [2:0]             rf_idx_s7,
  output logic                   rf_we,
  output logic [ADDR_WD-1:0]     rf_addr,
  output logic [REG_DATA_WD-1:0] rf_data,
  output logic                   err
);

  logic [ADDR_WD-1:0]     addr_r      [1:7];
  logic [2:0]             idx_r       [1:7];
  logic [REG_DATA_WD-1:0] data_r      [1:7];
  logic [REG_DATA_WD-1:0] data_nxt_s  [2:7];
  logic                   lat_valid_s [2:7];
  logic [REG_DATA_WD-1:0] lat_data_s  [2:7];
  logic                   expect_s    [2:7];
  logic [2:0]             iss_idx_s;

  function automatic logic [2:0] lat_of(input logic [2:0] idx);
    case (idx)
      3'd1:       lat_of = 3'd2;
      3'd2, 3'd4: lat_of = 3'd3;
      3'd5:       lat_of = 3'd4;
      3'd3, 3'd6: lat_of = 3'd6;
      3'd7:       lat_of = 3'd7;
      default:    lat_of = 3'd0;
    endcase
  endfunction

  function automatic logic idx_legal(input logic [2:0] idx);
    if (idx == 3'd0) begin
      idx_legal = 1'b1;
    end else if (PIPE == 0) begin
      idx_legal = (idx == 3'd1) || (idx == 3'd2) || (idx == 3'd3) ||
                  (idx == 3'd4) || (idx == 3'd7);
    end else begin
      idx_legal = (idx == 3'd5) || (idx == 3'd6);
    end
  endfunction

  // Map the result buses onto the stage they feed; no latency-5 class exists.
  always_comb begin
    lat_valid_s[2] = lat2_valid;  lat_data_s[2] = lat2_data;
    lat_valid_s[3] = lat3_valid;  lat_data_s[3] = lat3_data;
    lat_valid_s[4] = lat4_valid;  lat_data_s[4] = lat4_data;
    lat_valid_s[5] = 1'b0;        lat_data_s[5] = '0;
    lat_valid_s[6] = lat6_valid;  lat_data_s[6] = lat6_data;
    lat_valid_s[7] = lat7_valid;  lat_data_s[7] = lat7_data;
  end

  // Legalise the issued index and select captured or shifted data per stage.
  always_comb begin
    iss_idx_s = idx_legal(iss_idx) ? iss_idx : 3'd0;
    for (int k = 2; k <= 7; k++) begin
      expect_s[k] = (lat_of(idx_r[k-1]) == 3'(k));
      if (expect_s[k] && lat_valid_s[k]) begin
        data_nxt_s[k] = lat_data_s[k];
      end else begin
        data_nxt_s[k] = data_r[k-1];
      end
    end
  end

  // Stage shift register plus the s8 write-back register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 1; k <= 7; k++) begin
        addr_r[k] <= '0;
        idx_r[k]  <= 3'd0;
        data_r[k] <= '0;
      end
      rf_we   <= 1'b0;
      rf_addr <= '0;
      rf_data <= '0;
    end else begin
      if (iss_valid) begin
        addr_r[1] <= iss_rt_addr;
        idx_r[1]  <= iss_idx_s;
      end else begin
        addr_r[1] <= '0;
        idx_r[1]  <= 3'd0;
      end
      data_r[1] <= '0;
      for (int k = 2; k <= 7; k++) begin
        addr_r[k] <= addr_r[k-1];
        idx_r[k]  <= idx_r[k-1];
        data_r[k] <= data_nxt_s[k];
      end
      rf_we <= (idx_r[7] != 3'd0);
      if (idx_r[7] != 3'd0) begin
        rf_addr <= addr_r[7];
        rf_data <= data_r[7];
      end else begin
        rf_addr <= '0;
        rf_data <= '0;
      end
    end
  end

  assign rf_addr_s2 = addr_r[2];  assign rf_idx_s2 = idx_r[2];  assign rf_data_s2 = data_r[2];
  assign rf_addr_s3 = addr_r[3];  assign rf_idx_s3 = idx_r[3];  assign rf_data_s3 = data_r[3];
  assign rf_addr_s4 = addr_r[4];  assign rf_idx_s4 = idx_r[4];  assign rf_data_s4 = data_r[4];
  assign rf_addr_s5 = addr_r[5];  assign rf_idx_s5 = idx_r[5];  assign rf_data_s5 = data_r[5];
  assign rf_addr_s6 = addr_r[6];  assign rf_idx_s6 = idx_r[6];  assign rf_data_s6 = data_r[6];
  assign rf_addr_s7 = addr_r[7];  assign rf_idx_s7 = idx_r[7];  assign rf_data_s7 = data_r[7];

`ifdef RESULT_PIPE_CHECK_EN
  logic err_r;
  logic err_set_s;

  // A stage expecting a result without one, or a result nobody expects, is a protocol error.
  always_comb begin
    err_set_s = iss_valid && (iss_idx != 3'd0) && !idx_legal(iss_idx);
    for (int k = 2; k <= 7; k++) begin
      if (expect_s[k] != lat_valid_s[k]) begin
        err_set_s = 1'b1;
      end else begin
        err_set_s = err_set_s;
      end
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r | err_set_s;
    end
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_result_stage_pipe.sv
// Self-checking bench for result_stage_pipe: vector table, an age-based reference
// model under random and patterned issue, and reset / unexpected-result sequences.
module tb_result_stage_pipe;
  localparam int AW = 7;
  localparam int DW = 128;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          iss_valid;
  logic [AW-1:0] iss_rt_addr;
  logic [2:0]    iss_idx;
  logic          lat_v [2:7];
  logic [DW-1:0] lat_d [2:7];

  logic [AW-1:0] e_addr [2:7];
  logic [AW-1:0] o_addr [2:7];
  logic [2:0]    e_idx  [2:7];
  logic [2:0]    o_idx  [2:7];
  logic [DW-1:0] e_data [2:7];
  logic [DW-1:0] o_data [2:7];
  logic          e_we, o_we, e_err, o_err;
  logic [AW-1:0] e_wa, o_wa;
  logic [DW-1:0] e_wd, o_wd;

  result_stage_pipe #(.PIPE(0), .REG_DATA_WD(DW), .ADDR_WD(AW)) dut_even (
    .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_rt_addr(iss_rt_addr), .iss_idx(iss_idx),
    .lat2_valid(lat_v[2]), .lat2_data(lat_d[2]), .lat3_valid(lat_v[3]), .lat3_data(lat_d[3]),
    .lat4_valid(lat_v[4]), .lat4_data(lat_d[4]), .lat6_valid(lat_v[6]), .lat6_data(lat_d[6]),
    .lat7_valid(lat_v[7]), .lat7_data(lat_d[7]),
    .rf_addr_s2(e_addr[2]), .rf_addr_s3(e_addr[3]), .rf_addr_s4(e_addr[4]),
    .rf_addr_s5(e_addr[5]), .rf_addr_s6(e_addr[6]), .rf_addr_s7(e_addr[7]),
    .rf_data_s2(e_data[2]), .rf_data_s3(e_data[3]), .rf_data_s4(e_data[4]),
    .rf_data_s5(e_data[5]), .rf_data_s6(e_data[6]), .rf_data_s7(e_data[7]),
    .rf_idx_s2(e_idx[2]), .rf_idx_s3(e_idx[3]), .rf_idx_s4(e_idx[4]),
    .rf_idx_s5(e_idx[5]), .rf_idx_s6(e_idx[6]), .rf_idx_s7(e_idx[7]),
    .rf_we(e_we), .rf_addr(e_wa), .rf_data(e_wd), .err(e_err));

  result_stage_pipe #(.PIPE(1), .REG_DATA_WD(DW), .ADDR_WD(AW)) dut_odd (
    .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_rt_addr(iss_rt_addr), .iss_idx(iss_idx),
    .lat2_valid(lat_v[2]), .lat2_data(lat_d[2]), .lat3_valid(lat_v[3]), .lat3_data(lat_d[3]),
    .lat4_valid(lat_v[4]), .lat4_data(lat_d[4]), .lat6_valid(lat_v[6]), .lat6_data(lat_d[6]),
    .lat7_valid(lat_v[7]), .lat7_data(lat_d[7]),
    .rf_addr_s2(o_addr[2]), .rf_addr_s3(o_addr[3]), .rf_addr_s4(o_addr[4]),
    .rf_addr_s5(o_addr[5]), .rf_addr_s6(o_addr[6]), .rf_addr_s7(o_addr[7]),
    .rf_data_s2(o_data[2]), .rf_data_s3(o_data[3]), .rf_data_s4(o_data[4]),
    .rf_data_s5(o_data[5]), .rf_data_s6(o_data[6]), .rf_data_s7(o_data[7]),
    .rf_idx_s2(o_idx[2]), .rf_idx_s3(o_idx[3]), .rf_idx_s4(o_idx[4]),
    .rf_idx_s5(o_idx[5]), .rf_idx_s6(o_idx[6]), .rf_idx_s7(o_idx[7]),
    .rf_we(o_we), .rf_addr(o_wa), .rf_data(o_wd), .err(o_err));

  // View of whichever pipe the current test targets.
  logic          pipe_sel;
  logic [AW-1:0] s_addr [2:7];
  logic [2:0]    s_idx  [2:7];
  logic [DW-1:0] s_data [2:7];
  logic          s_we, s_err;
  logic [AW-1:0] s_wa;
  logic [DW-1:0] s_wd;
  always_comb begin
    for (int k = 2; k <= 7; k++) begin
      s_addr[k] = pipe_sel ? o_addr[k] : e_addr[k];
      s_idx[k]  = pipe_sel ? o_idx[k]  : e_idx[k];
      s_data[k] = pipe_sel ? o_data[k] : e_data[k];
    end
    s_we  = pipe_sel ? o_we  : e_we;
    s_wa  = pipe_sel ? o_wa  : e_wa;
    s_wd  = pipe_sel ? o_wd  : e_wd;
    s_err = pipe_sel ? o_err : e_err;
  end

  // Spec latency per unit index (0 = none).
  int lat_tab [8] = '{0, 2, 3, 6, 3, 4, 6, 7};
  int checks = 0;
  int errors = 0;
  bit chk_en;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    iss_valid = 1'b0;
    iss_rt_addr = '0;
    iss_idx = 3'd0;
    for (int k = 2; k <= 7; k++) begin
      lat_v[k] = 1'b0;
      lat_d[k] = '0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_in();
    repeat (2) tick();
    rst = 1'b1;
  endtask

  typedef struct {
    logic          pipe;
    logic [AW-1:0] rt;
    logic [2:0]    idx;
    logic [DW-1:0] data;
    bit            drive;
    bit            exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    bit            exp_err;
  } vec_t;

  // Age-based model: an op issued at cycle c sits in stage K during cycle c+K,
  // carries its result from age L onward, and writes back at age 8.
  task automatic run_model(input logic pipe, input int n, input int mode);
    bit            op_v [100];
    logic [AW-1:0] op_a [100];
    logic [2:0]    op_i [100];
    logic [DW-1:0] op_d [100];
    int ev [6] = '{0, 1, 2, 3, 4, 7};
    int od [3] = '{0, 5, 6};
    int cyc_pat [5] = '{1, 2, 4, 3, 7};
    int wr_cnt = 0;
    int exp_wr = 0;
    for (int c = 0; c < 100; c++) begin
      op_v[c] = 1'b0; op_a[c] = '0; op_i[c] = 3'd0; op_d[c] = '0;
    end
    for (int c = 0; c < n; c++) begin
      op_a[c] = AW'($urandom);
      op_d[c] = {$urandom, $urandom, $urandom, $urandom};
      if (mode == 0) begin
        op_v[c] = ($urandom_range(3) != 0);
        op_i[c] = pipe ? 3'(od[$urandom_range(2)]) : 3'(ev[$urandom_range(5)]);
      end else if (mode == 1) begin
        op_v[c] = 1'b1;
        op_i[c] = 3'(cyc_pat[c % 5]);
      end else begin
        op_v[c] = (c == 0) || (c == 4);
        op_i[c] = (c == 0) ? 3'd3 : 3'd1;
        op_a[c] = 7'd9;
      end
      if (op_v[c] && op_i[c] != 3'd0) exp_wr++;
    end
    pipe_sel = pipe;
    do_reset();
    for (int c = 0; c < n + 10; c++) begin
      tick();
      clear_in();
      if (c < n && op_v[c]) begin
        iss_valid = 1'b1; iss_rt_addr = op_a[c]; iss_idx = op_i[c];
      end
      for (int l = 2; l <= 7; l++) begin
        int src;
        src = c - l + 1;
        if (src >= 0 && src < n && op_v[src] && op_i[src] != 3'd0 && lat_tab[op_i[src]] == l) begin
          lat_v[l] = 1'b1; lat_d[l] = op_d[src];
        end
      end
      for (int k = 2; k <= 7; k++) begin
        int src;
        logic [AW-1:0] ea; logic [2:0] ei; logic [DW-1:0] ed;
        src = c - k;
        ea = '0; ei = 3'd0; ed = '0;
        if (src >= 0 && src < n && op_v[src]) begin
          ea = op_a[src]; ei = op_i[src];
          if (op_i[src] != 3'd0 && k >= lat_tab[op_i[src]]) ed = op_d[src];
        end
        chk($sformatf("m%0d s%0d_addr c%0d", mode, k, c), DW'(s_addr[k]), DW'(ea));
        chk($sformatf("m%0d s%0d_idx c%0d", mode, k, c), DW'(s_idx[k]), DW'(ei));
        chk($sformatf("m%0d s%0d_data c%0d", mode, k, c), s_data[k], ed);
      end
      begin
        int src;
        bit ew;
        src = c - 8;
        ew = (src >= 0 && src < n && op_v[src] && op_i[src] != 3'd0);
        chk($sformatf("m%0d rf_we c%0d", mode, c), DW'(s_we), DW'(ew));
        chk($sformatf("m%0d rf_addr c%0d", mode, c), DW'(s_wa), ew ? DW'(op_a[src]) : '0);
        chk($sformatf("m%0d rf_data c%0d", mode, c), s_wd, ew ? op_d[src] : '0);
      end
      if (s_we) wr_cnt++;
    end
    chk($sformatf("m%0d write_count", mode), DW'(wr_cnt), DW'(exp_wr));
    chk($sformatf("m%0d err", mode), DW'(s_err), '0);
  endtask

  vec_t vecs [11];

  initial begin
`ifdef RESULT_PIPE_CHECK_EN
    chk_en = 1'b1;
`else
    chk_en = 1'b0;
`endif
    pipe_sel = 1'b0;
    //              pipe  rt     idx   data            drv  we    addr   data            err
    vecs[0]  = '{1'b0, 7'd5, 3'd1, 128'hA5,        1'b1, 1'b1, 7'd5, 128'hA5,        1'b0};
    vecs[1]  = '{1'b0, 7'd9, 3'd3, 128'h1234_5678, 1'b1, 1'b1, 7'd9, 128'h1234_5678, 1'b0};
    vecs[2]  = '{1'b0, 7'd1, 3'd7, 128'hDEAD,      1'b1, 1'b1, 7'd1, 128'hDEAD,      1'b0};
    vecs[3]  = '{1'b0, 7'd2, 3'd2, 128'h22,        1'b1, 1'b1, 7'd2, 128'h22,        1'b0};
    vecs[4]  = '{1'b0, 7'd3, 3'd4, 128'h44,        1'b1, 1'b1, 7'd3, 128'h44,        1'b0};
    vecs[5]  = '{1'b1, 7'd3, 3'd5, 128'h77,        1'b0, 1'b1, 7'd3, 128'h0,         1'b1};
    vecs[6]  = '{1'b0, 7'd4, 3'd6, 128'h0,         1'b0, 1'b0, 7'd0, 128'h0,         1'b1};
    vecs[7]  = '{1'b1, 7'd7, 3'd6, 128'h66,        1'b1, 1'b1, 7'd7, 128'h66,        1'b0};
    vecs[8]  = '{1'b1, 7'd8, 3'd1, 128'h0,         1'b0, 1'b0, 7'd0, 128'h0,         1'b1};
    vecs[9]  = '{1'b0, 7'd4, 3'd0, 128'h0,         1'b0, 1'b0, 7'd0, 128'h0,         1'b0};
    vecs[10] = '{1'b1, 7'd6, 3'd5, {4{32'hCAFE_F00D}}, 1'b1, 1'b1, 7'd6, {4{32'hCAFE_F00D}}, 1'b0};

    for (int i = 0; i < 11; i++) begin
      int l;
      pipe_sel = vecs[i].pipe;
      l = lat_tab[vecs[i].idx];
      do_reset();
      tick();
      iss_valid = 1'b1; iss_rt_addr = vecs[i].rt; iss_idx = vecs[i].idx;
      for (int k = 1; k <= 9; k++) begin
        tick();
        clear_in();
        if (vecs[i].drive && k == l - 1) begin
          lat_v[l] = 1'b1; lat_d[l] = vecs[i].data;
        end
        if (k == 2) chk($sformatf("v%0d s2_idx", i), DW'(s_idx[2]), vecs[i].exp_we ? DW'(vecs[i].idx) : '0);
        if (k == l && vecs[i].drive) chk($sformatf("v%0d s%0d_data", i, l), s_data[l], vecs[i].data);
        if (!vecs[i].drive && vecs[i].exp_we && k >= l)
          chk($sformatf("v%0d err_k%0d", i, k), DW'(s_err), DW'(chk_en));
        if (k == 8) begin
          chk($sformatf("v%0d rf_we", i), DW'(s_we), DW'(vecs[i].exp_we));
          chk($sformatf("v%0d rf_addr", i), DW'(s_wa), DW'(vecs[i].exp_addr));
          chk($sformatf("v%0d rf_data", i), s_wd, vecs[i].exp_data);
        end
        if (k == 9) chk($sformatf("v%0d rf_we_after", i), DW'(s_we), '0);
      end
      chk($sformatf("v%0d err", i), DW'(s_err), DW'(vecs[i].exp_err & chk_en));
    end

    run_model(1'b0, 5, 2);
    run_model(1'b0, 20, 1);
    run_model(1'b0, 60, 0);
    run_model(1'b1, 40, 0);

    // Unexpected latency-3 result on an empty pipe: ignored, flags err when checking.
    pipe_sel = 1'b0;
    do_reset();
    tick();
    lat_v[3] = 1'b1; lat_d[3] = 128'hBAD;
    tick();
    clear_in();
    chk("unexp s3_data", s_data[3], '0);
    chk("unexp err", DW'(s_err), DW'(chk_en));

    // Reset asserted mid-flight with three ops in the pipe.
    do_reset();
    tick();
    iss_valid = 1'b1; iss_rt_addr = 7'd1; iss_idx = 3'd1;
    tick();
    clear_in();
    iss_valid = 1'b1; iss_rt_addr = 7'd2; iss_idx = 3'd2;
    lat_v[2] = 1'b1; lat_d[2] = 128'h11;
    tick();
    clear_in();
    iss_valid = 1'b1; iss_rt_addr = 7'd3; iss_idx = 3'd7;
    chk("rst pre s2_idx", DW'(s_idx[2]), DW'(3'd1));
    tick();
    clear_in();
    rst = 1'b0;
    #1;
    for (int k = 2; k <= 7; k++) begin
      chk($sformatf("rst s%0d_addr", k), DW'(s_addr[k]), '0);
      chk($sformatf("rst s%0d_idx", k), DW'(s_idx[k]), '0);
      chk($sformatf("rst s%0d_data", k), s_data[k], '0);
    end
    chk("rst rf_we", DW'(s_we), '0);
    chk("rst rf_addr", DW'(s_wa), '0);
    chk("rst rf_data", s_wd, '0);
    chk("rst err", DW'(s_err), '0);
    repeat (2) tick();
    rst = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk($sformatf("post_rst rf_we c%0d", k), DW'(s_we), '0);
    end
    chk("post_rst err", DW'(s_err), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
